// File: rtl/cache_mem_ctrl_if.sv
// Command/response and memory-port bundle shared by the cache FSM, the
// line-transfer engine and the memory side.
interface cache_mem_ctrl_if #(
  parameter int unsigned PA_WIDTH  = 32,
  parameter int unsigned MEM_WIDTH = 32,
  parameter int unsigned BLK_BITS  = 128
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_wb;
  logic                 req_fill;
  logic [PA_WIDTH-1:0]  wb_addr;
  logic [BLK_BITS-1:0]  wb_data;
  logic [PA_WIDTH-1:0]  fill_addr;
  logic                 done;
  logic                 err;
  logic [BLK_BITS-1:0]  fill_data;
  logic                 mem_req;
  logic                 mem_we;
  logic [PA_WIDTH-1:0]  mem_addr;
  logic [MEM_WIDTH-1:0] mem_wr_data;
  logic                 mem_ack;
  logic [MEM_WIDTH-1:0] mem_rd_data;

  modport slave (
    input  req_valid, req_wb, req_fill, wb_addr, wb_data, fill_addr, mem_ack, mem_rd_data,
    output req_ready, done, err, fill_data, mem_req, mem_we, mem_addr, mem_wr_data
  );

  modport master (
    output req_valid, req_wb, req_fill, wb_addr, wb_data, fill_addr, mem_ack, mem_rd_data,
    input  req_ready, done, err, fill_data, mem_req, mem_we, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/cache_mem_ctrl.sv
// Line-transfer engine: optional victim writeback then optional block fill,
// moved as sequential beats over a single-outstanding req/ack memory port.
module cache_mem_ctrl #(
  parameter int unsigned PA_WIDTH  = 32,
  parameter int unsigned MEM_WIDTH = 32,
  parameter int unsigned BLK_BITS  = 128,
  parameter int unsigned TIMEOUT   = 16
) (
  input logic             clk,
  input logic             rst_n,
  cache_mem_ctrl_if.slave bus
);
  localparam int unsigned BEATS      = BLK_BITS / MEM_WIDTH;
  localparam int unsigned BEAT_BYTES = MEM_WIDTH / 8;
  localparam int unsigned OFF_BITS   = $clog2(BLK_BITS / 8);
  localparam int unsigned BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned TMO_W      = $clog2(TIMEOUT);
  localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [TMO_W-1:0]    TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [PA_WIDTH-1:0] OFF_MASK  = PA_WIDTH'((64'd1 << OFF_BITS) - 64'd1);

  typedef enum logic [1:0] {IDLE, WB, FILL, FIN} state_e;

  state_e               state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [PA_WIDTH-1:0]  wb_addr_q, wb_addr_d;
  logic [PA_WIDTH-1:0]  fill_addr_q, fill_addr_d;
  logic [BLK_BITS-1:0]  wb_data_q, wb_data_d;
  logic                 fill_en_q, fill_en_d;
  logic [BLK_BITS-1:0]  fill_data_q, fill_data_d;
  logic                 req_ready_q, req_ready_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [PA_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [MEM_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic                 beat_ack_c;

  // Next-state, beat bookkeeping and next values of the registered outputs.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    tmo_d         = tmo_q;
    wb_addr_d     = wb_addr_q;
    fill_addr_d   = fill_addr_q;
    wb_data_d     = wb_data_q;
    fill_en_d     = fill_en_q;
    fill_data_d   = fill_data_q;
    err_d         = 1'b0;
    beat_ack_c    = mem_req_q && bus.mem_ack;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          wb_addr_d   = bus.wb_addr & ~OFF_MASK;
          fill_addr_d = bus.fill_addr & ~OFF_MASK;
          wb_data_d   = bus.wb_data;
          fill_en_d   = bus.req_fill;
          beat_d      = '0;
          tmo_d       = '0;
          if (bus.req_wb) begin
            state_d = WB;
          end else if (bus.req_fill) begin
            state_d     = FILL;
            fill_data_d = '0;
          end else begin
            state_d = FIN;
          end
        end
      end
      WB, FILL: begin
        if (beat_ack_c) begin
          if (state_q == FILL) begin
            fill_data_d[beat_q*MEM_WIDTH +: MEM_WIDTH] = bus.mem_rd_data;
          end
          tmo_d = '0;
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (state_q == WB && fill_en_q) begin
              state_d     = FILL;
              fill_data_d = '0;
            end else begin
              state_d = FIN;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else if (tmo_q == TMO_LAST) begin
          // Stalled beat: abandon the rest of the command.
          state_d = FIN;
          err_d   = 1'b1;
          tmo_d   = '0;
          beat_d  = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      FIN: state_d = IDLE;
    endcase

    req_ready_d   = (state_d == IDLE);
    done_d        = (state_d == FIN);
    mem_req_d     = (state_d == WB) || (state_d == FILL);
    mem_we_d      = (state_d == WB);
    mem_addr_d    = '0;
    mem_wr_data_d = '0;
    if (mem_req_d) begin
      mem_addr_d = ((state_d == WB) ? wb_addr_d : fill_addr_d)
                 + PA_WIDTH'(beat_d) * PA_WIDTH'(BEAT_BYTES);
    end
    if (state_d == WB) begin
      mem_wr_data_d = wb_data_d[beat_d*MEM_WIDTH +: MEM_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      tmo_q         <= '0;
      wb_addr_q     <= '0;
      fill_addr_q   <= '0;
      wb_data_q     <= '0;
      fill_en_q     <= 1'b0;
      fill_data_q   <= '0;
      req_ready_q   <= 1'b1;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      tmo_q         <= tmo_d;
      wb_addr_q     <= wb_addr_d;
      fill_addr_q   <= fill_addr_d;
      wb_data_q     <= wb_data_d;
      fill_en_q     <= fill_en_d;
      fill_data_q   <= fill_data_d;
      req_ready_q   <= req_ready_d;
      done_q        <= done_d;
      err_q         <= err_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.fill_data   = fill_data_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;
endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Bench for cache_mem_ctrl: transaction-level beat-queue model, per-cycle
// compare process, directed latency/timeout/reset cases and random commands.
module tb_cache_mem_ctrl;
  localparam int unsigned PA_WIDTH   = 32;
  localparam int unsigned MEM_WIDTH  = 32;
  localparam int unsigned BLK_BITS   = 128;
  localparam int unsigned TIMEOUT    = 16;
  localparam int unsigned BEATS      = BLK_BITS / MEM_WIDTH;
  localparam int unsigned BEAT_BYTES = MEM_WIDTH / 8;
  localparam int unsigned BLK_BYTES  = BLK_BITS / 8;
  localparam int          BUDGET     = 300;

  typedef struct {
    bit                   we;
    logic [PA_WIDTH-1:0]  addr;
    logic [MEM_WIDTH-1:0] wdata;
  } beat_t;
  typedef enum {M_IDLE, M_BUSY, M_FIN} mph_e;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  cache_mem_ctrl_if #(.PA_WIDTH(PA_WIDTH), .MEM_WIDTH(MEM_WIDTH), .BLK_BITS(BLK_BITS)) bus ();

  cache_mem_ctrl #(
    .PA_WIDTH(PA_WIDTH), .MEM_WIDTH(MEM_WIDTH), .BLK_BITS(BLK_BITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [BLK_BITS-1:0] act,
                       input logic [BLK_BITS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  int                   ack_mode    = 0;  // 0 always, 1 fixed delay, 2 random, 3 stall after N acks
  int                   ack_delay   = 0;
  int                   stall_after = 0;
  int                   dly_cnt     = 0;
  int                   acks_given  = 0;
  int                   nreads      = 0;
  bit                   use_pat     = 1'b0;
  logic [MEM_WIDTH-1:0] rd_base     = '0;
  beat_t                log_q[$];

  always @(negedge clk) begin
    logic  a;
    beat_t lb;
    a = 1'b0;
    case (ack_mode)
      0:       a = 1'b1;
      1:       a = bus.mem_req && (dly_cnt == ack_delay);
      2:       a = ($urandom_range(0, 3) != 0);
      default: a = bus.mem_req && (acks_given < stall_after);
    endcase
    bus.mem_rd_data = use_pat ? MEM_WIDTH'(rd_base + MEM_WIDTH'(acks_given)) : MEM_WIDTH'($urandom);
    if (bus.mem_req && !bus.mem_we) nreads++;
    if (bus.mem_req) begin
      if (a) begin
        lb.we = bus.mem_we; lb.addr = bus.mem_addr; lb.wdata = bus.mem_wr_data;
        log_q.push_back(lb);
        acks_given++;
        dly_cnt = 0;
      end else begin
        dly_cnt++;
      end
    end else begin
      dly_cnt = 0;
    end
    bus.mem_ack = a;
  end

  // ---------------- behavioural model ----------------
  mph_e                mph = M_IDLE;
  beat_t               mq[$];
  int                  mwait = 0;
  int                  mrd   = 0;
  bit                  merr  = 1'b0;
  logic [BLK_BITS-1:0] mfill = '0;
  bit                  mfill_open  = 1'b0;
  bit                  mfill_valid = 1'b1;
  logic [PA_WIDTH-1:0] m_wbb, m_flb;
  beat_t               mb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mph = M_IDLE; mq.delete(); mwait = 0; mrd = 0; merr = 1'b0;
      mfill = '0; mfill_open = 1'b0; mfill_valid = 1'b1;
    end else begin
      case (mph)
        M_IDLE: if (bus.req_valid) begin
          m_wbb = bus.wb_addr   - (bus.wb_addr   % BLK_BYTES);
          m_flb = bus.fill_addr - (bus.fill_addr % BLK_BYTES);
          for (int b = 0; b < int'(BEATS); b++) if (bus.req_wb) begin
            mb.we = 1'b1; mb.addr = m_wbb + PA_WIDTH'(b * BEAT_BYTES);
            mb.wdata = bus.wb_data[b*MEM_WIDTH +: MEM_WIDTH];
            mq.push_back(mb);
          end
          for (int b = 0; b < int'(BEATS); b++) if (bus.req_fill) begin
            mb.we = 1'b0; mb.addr = m_flb + PA_WIDTH'(b * BEAT_BYTES); mb.wdata = '0;
            mq.push_back(mb);
          end
          mwait = 0; mrd = 0; merr = 1'b0; mfill_open = 1'b0;
          mph = (mq.size() > 0) ? M_BUSY : M_FIN;
        end
        M_BUSY: if (bus.mem_ack) begin
          mb = mq.pop_front();
          if (!mb.we) begin
            mfill[mrd*MEM_WIDTH +: MEM_WIDTH] = bus.mem_rd_data;
            mrd++;
          end
          mwait = 0;
          if (mq.size() == 0) mph = M_FIN;
        end else begin
          mwait++;
          if (mwait == int'(TIMEOUT)) begin
            mph = M_FIN; merr = 1'b1; mq.delete(); mfill_valid = 1'b0;
          end
        end
        default: begin mph = M_IDLE; merr = 1'b0; end
      endcase
      if (mph == M_BUSY && !mfill_open && !mq[0].we) begin
        mfill = '0; mfill_open = 1'b1; mfill_valid = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) if (rst_n) begin
    check("req_ready", BLK_BITS'(bus.req_ready), BLK_BITS'(mph == M_IDLE));
    check("done",      BLK_BITS'(bus.done),      BLK_BITS'(mph == M_FIN));
    check("mem_req",   BLK_BITS'(bus.mem_req),   BLK_BITS'(mph == M_BUSY));
    if (mph == M_FIN) check("err", BLK_BITS'(bus.err), BLK_BITS'(merr));
    if (mph != M_BUSY && mfill_valid) check("fill_data", bus.fill_data, mfill);
    if (mph == M_BUSY && mq.size() > 0) begin
      check("mem_we",   BLK_BITS'(bus.mem_we),   BLK_BITS'(mq[0].we));
      check("mem_addr", BLK_BITS'(bus.mem_addr), BLK_BITS'(mq[0].addr));
      if (mq[0].we) check("mem_wr_data", BLK_BITS'(bus.mem_wr_data), BLK_BITS'(mq[0].wdata));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input bit wb, input bit fill, input logic [PA_WIDTH-1:0] wa,
                       input logic [BLK_BITS-1:0] wd, input logic [PA_WIDTH-1:0] fa,
                       output int t_acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < BUDGET) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL issue_wait: req_ready=0 after %0d cycles, expected 1", BUDGET);
    end
    acks_given = 0; nreads = 0; log_q.delete();
    bus.req_valid = 1'b1; bus.req_wb = wb; bus.req_fill = fill;
    bus.wb_addr = wa; bus.wb_data = wd; bus.fill_addr = fa;
    t_acc = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wb = 1'($urandom); bus.req_fill = 1'($urandom);
    bus.wb_addr = $urandom; bus.fill_addr = $urandom;
    bus.wb_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(input int t_acc, output int lat, output logic e);
    int n;
    n = 0; lat = -1; e = 1'bx;
    while (!bus.done && n < BUDGET) begin @(negedge clk); n++; end
    if (bus.done) begin
      lat = cyc - t_acc; e = bus.err;
    end else begin
      n_checks++; n_fail++;
      $display("FAIL wait_done: done=0 after %0d cycles, expected 1", BUDGET);
    end
  endtask

  task automatic run(input bit wb, input bit fill, input logic [PA_WIDTH-1:0] wa,
                     input logic [BLK_BITS-1:0] wd, input logic [PA_WIDTH-1:0] fa,
                     output int lat, output logic e);
    int t0;
    issue(wb, fill, wa, wd, fa, t0);
    wait_done(t0, lat, e);
  endtask

  logic [PA_WIDTH-1:0] t1_addr [4] = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};

  initial begin
    int   lat, t0, n, ndone, first;
    logic e;
    bus.req_valid = 1'b0; bus.req_wb = 1'b0; bus.req_fill = 1'b0;
    bus.wb_addr = '0; bus.wb_data = '0; bus.fill_addr = '0;
    bus.mem_ack = 1'b0; bus.mem_rd_data = '0;

    repeat (2) @(negedge clk);
    check("rst_req_ready",   BLK_BITS'(bus.req_ready),   BLK_BITS'(1));
    check("rst_done",        BLK_BITS'(bus.done),        '0);
    check("rst_err",         BLK_BITS'(bus.err),         '0);
    check("rst_mem_req",     BLK_BITS'(bus.mem_req),     '0);
    check("rst_mem_we",      BLK_BITS'(bus.mem_we),      '0);
    check("rst_mem_addr",    BLK_BITS'(bus.mem_addr),    '0);
    check("rst_mem_wr_data", BLK_BITS'(bus.mem_wr_data), '0);
    check("rst_fill_data",   bus.fill_data,              '0);
    rst_n = 1'b1;

    // Fill only, ack every cycle.
    ack_mode = 0; use_pat = 1'b1; rd_base = 32'hA0;
    run(1'b0, 1'b1, '0, '0, 32'h0000_1234, lat, e);
    check("t1_latency", BLK_BITS'(lat), BLK_BITS'(5));
    check("t1_err", BLK_BITS'(e), '0);
    check("t1_fill_data", bus.fill_data, 128'h000000A3_000000A2_000000A1_000000A0);
    check("t1_beats", BLK_BITS'(log_q.size()), BLK_BITS'(4));
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", BLK_BITS'(log_q[i].addr), BLK_BITS'(t1_addr[i]));
      check("t1_we", BLK_BITS'(log_q[i].we), '0);
    end

    // Writeback then fill.
    run(1'b1, 1'b1, 32'h2000, 128'h00000044_00000033_00000022_00000011, 32'h3000, lat, e);
    check("t2_latency", BLK_BITS'(lat), BLK_BITS'(9));
    check("t2_beats", BLK_BITS'(log_q.size()), BLK_BITS'(8));
    check("t2_w0_data", BLK_BITS'(log_q[0].wdata), BLK_BITS'(32'h11));
    check("t2_w0_we", BLK_BITS'(log_q[0].we), BLK_BITS'(1));
    check("t2_w3_data", BLK_BITS'(log_q[3].wdata), BLK_BITS'(32'h44));
    check("t2_w3_addr", BLK_BITS'(log_q[3].addr), BLK_BITS'(32'h200C));
    check("t2_r0_addr", BLK_BITS'(log_q[4].addr), BLK_BITS'(32'h3000));
    check("t2_r3_addr", BLK_BITS'(log_q[7].addr), BLK_BITS'(32'h300C));
    check("t2_r3_we", BLK_BITS'(log_q[7].we), '0);

    // Fill with three wait cycles per beat.
    ack_mode = 1; ack_delay = 3; rd_base = 32'hB0;
    run(1'b0, 1'b1, '0, '0, 32'h4008, lat, e);
    check("t3_latency", BLK_BITS'(lat), BLK_BITS'(17));
    check("t3_fill_data", bus.fill_data, 128'h000000B3_000000B2_000000B1_000000B0);

    // Memory stops answering on writeback beat 1.
    ack_mode = 3; stall_after = 1;
    run(1'b1, 1'b1, 32'h2040, {4{32'h5A5A_0000}}, 32'h3040, lat, e);
    check("t4_latency", BLK_BITS'(lat), BLK_BITS'(18));
    check("t4_err", BLK_BITS'(e), BLK_BITS'(1));
    check("t4_no_fill_beats", BLK_BITS'(nreads), '0);
    @(negedge clk);
    check("t4_ready_after", BLK_BITS'(bus.req_ready), BLK_BITS'(1));

    // Reset pulsed during fill beat 2.
    ack_mode = 1; ack_delay = 3; rd_base = 32'hC0;
    issue(1'b0, 1'b1, '0, '0, 32'h5000, t0);
    n = 0;
    while (acks_given < 2 && n < BUDGET) begin @(negedge clk); n++; end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_mem_req_async", BLK_BITS'(bus.mem_req), '0);
    check("t5_fill_cleared", bus.fill_data, '0);
    check("t5_ready_in_rst", BLK_BITS'(bus.req_ready), BLK_BITS'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_done", BLK_BITS'(bus.done), '0);
    end
    rst_n = 1'b1;
    ack_mode = 0; rd_base = 32'hD0;
    run(1'b0, 1'b1, '0, '0, 32'h6000, lat, e);
    check("t5_latency", BLK_BITS'(lat), BLK_BITS'(5));
    check("t5_fill_data", bus.fill_data, 128'h000000D3_000000D2_000000D1_000000D0);

    // No-op commands with req_valid held high for six cycles.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wb = 1'b0; bus.req_fill = 1'b0;
    t0 = cyc; ndone = 0; first = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        if (first < 0) first = cyc - t0;
      end
      if (cyc - t0 >= 6) bus.req_valid = 1'b0;
    end
    check("t6_first_done", BLK_BITS'(first), BLK_BITS'(1));
    check("t6_done_count", BLK_BITS'(ndone), BLK_BITS'(3));

    // Random commands against the model.
    use_pat = 1'b0;
    for (int i = 0; i < 60; i++) begin
      ack_mode = $urandom_range(0, 3); ack_delay = $urandom_range(0, 4);
      stall_after = $urandom_range(0, 8);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(1'($urandom), 1'($urandom), $urandom, {$urandom, $urandom, $urandom, $urandom},
          $urandom, lat, e);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
